// File: rtl/fp32_pkg.sv
// Shared binary32 constants and divider state encoding.
package fp32_pkg;

    localparam logic [31:0] FP32_QNAN    = 32'h7FC0_0000;
    localparam logic [7:0]  FP32_BIAS    = 8'd127;
    localparam logic [7:0]  FP32_EXP_MAX = 8'd255;
    localparam logic [4:0]  DIV_ITERS    = 5'd27;

    typedef enum logic [1:0] {
        IDLE,
        DIV,
        NORM,
        DONE
    } state_t;

endpackage

// File: rtl/fp32_rnd_pack.sv
// Normalise a 27-bit quotient, round to nearest even, and pack binary32.
module fp32_rnd_pack
    import fp32_pkg::*;
(
    input  logic              sign,
    input  logic signed [9:0] e,
    input  logic [26:0]       q,
    input  logic              rem_nz,
    output logic [31:0]       word
);

    logic [23:0]       man;
    logic [23:0]       man_rnd;
    logic [24:0]       sum;
    logic              guard;
    logic              sticky;
    logic              inc;
    logic signed [9:0] e_norm;
    logic signed [9:0] e_rnd;

    always_comb begin
        man     = q[26:3];
        guard   = q[2];
        sticky  = |q[1:0] | rem_nz;
        e_norm  = e;
        man_rnd = '0;
        e_rnd   = '0;
        word    = '0;
        if (!q[26]) begin
            man    = q[25:2];
            guard  = q[1];
            sticky = q[0] | rem_nz;
            e_norm = e - 10'sd1;
        end
        inc = guard & (sticky | man[0]);
        sum = {1'b0, man} + {24'd0, inc};
        // A carry out of the mantissa leaves exactly 1.0, so shift and bump e.
        if (sum[24]) begin
            man_rnd = sum[24:1];
            e_rnd   = e_norm + 10'sd1;
        end else begin
            man_rnd = sum[23:0];
            e_rnd   = e_norm;
        end
        if (e_rnd >= $signed({2'b00, FP32_EXP_MAX}))
            word = {sign, 8'hFF, 23'd0};
        else if (e_rnd <= 10'sd0)
            word = {sign, 8'h00, 23'd0};
        else
            word = {sign, e_rnd[7:0], man_rnd[22:0]};
    end

endmodule

// File: rtl/fp32_div_seq.sv
// Sequential binary32 divider: one restoring-division bit per cycle.
module fp32_div_seq
    import fp32_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] z
);

    state_t            state;
    state_t            state_nxt;
    logic [23:0]       mb;
    logic              sign;
    logic signed [9:0] e;
    logic [4:0]        cnt;
    logic [26:0]       q;
    logic [24:0]       r;

    logic        a_zero, a_inf, a_nan;
    logic        b_zero, b_inf, b_nan;
    logic        s_in;
    logic        is_special;
    logic [31:0] special_z;
    logic        ge;
    logic [24:0] diff;
    logic [24:0] r_nxt;
    logic [31:0] word;

    assign a_zero = (a[30:23] == 8'd0);
    assign b_zero = (b[30:23] == 8'd0);
    assign a_inf  = (&a[30:23]) & ~(|a[22:0]);
    assign b_inf  = (&b[30:23]) & ~(|b[22:0]);
    assign a_nan  = (&a[30:23]) & (|a[22:0]);
    assign b_nan  = (&b[30:23]) & (|b[22:0]);
    assign s_in   = a[31] ^ b[31];

    always_comb begin
        is_special = 1'b1;
        special_z  = FP32_QNAN;
        if (a_nan | b_nan)
            special_z = FP32_QNAN;
        else if ((a_inf & b_inf) | (a_zero & b_zero))
            special_z = FP32_QNAN;
        else if (a_inf | b_zero)
            special_z = {s_in, 8'hFF, 23'd0};
        else if (a_zero | b_inf)
            special_z = {s_in, 8'h00, 23'd0};
        else
            is_special = 1'b0;
    end

    // Partial remainder stays below 2*mb, so 25 bits hold it after the shift.
    assign ge    = (r >= {1'b0, mb});
    assign diff  = r - {1'b0, mb};
    assign r_nxt = ge ? {diff[23:0], 1'b0} : {r[23:0], 1'b0};

    fp32_rnd_pack u_rnd_pack (
        .sign   (sign),
        .e      (e),
        .q      (q),
        .rem_nz (|r),
        .word   (word)
    );

    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        unique case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid)
                    state_nxt = is_special ? DONE : DIV;
            end
            DIV: begin
                if (cnt == DIV_ITERS - 5'd1)
                    state_nxt = NORM;
            end
            NORM: state_nxt = DONE;
            DONE: begin
                out_valid = 1'b1;
                if (out_ready)
                    state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
            mb    <= '0;
            sign  <= 1'b0;
            e     <= '0;
            cnt   <= '0;
            q     <= '0;
            r     <= '0;
            z     <= '0;
        end else begin
            state <= state_nxt;
            unique case (state)
                IDLE: begin
                    if (in_valid) begin
                        mb   <= {1'b1, b[22:0]};
                        sign <= s_in;
                        e    <= $signed({2'b00, a[30:23]})
                              - $signed({2'b00, b[30:23]})
                              + $signed({2'b00, FP32_BIAS});
                        cnt  <= '0;
                        q    <= '0;
                        r    <= {1'b0, 1'b1, a[22:0]};
                        if (is_special)
                            z <= special_z;
                    end
                end
                DIV: begin
                    q   <= {q[25:0], ge};
                    r   <= r_nxt;
                    cnt <= cnt + 5'd1;
                end
                NORM: z <= word;
                DONE: ;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_fp32_div_seq.sv
// Directed and random checks of fp32_div_seq against an arithmetic model.
module tb_fp32_div_seq;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] a;
    logic [31:0] b;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] z;

    int checks = 0;
    int failures = 0;

    fp32_div_seq dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .z         (z)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic bit is_special(input logic [31:0] x, input logic [31:0] y);
        return (x[30:23] == 8'd0) || (x[30:23] == 8'hFF) ||
               (y[30:23] == 8'd0) || (y[30:23] == 8'hFF);
    endfunction

    // Exact quotient via wide integer division, then RNE on the leading 24 bits.
    function automatic logic [31:0] ref_div(input logic [31:0] x, input logic [31:0] y);
        bit               s;
        bit               xz, yz, xi, yi, xn, yn;
        longint unsigned  n, qq, rr, man, rest, half;
        int               sh, ex;
        bit               up;
        s  = x[31] ^ y[31];
        xz = (x[30:23] == 0);
        yz = (y[30:23] == 0);
        xi = (x[30:23] == 255) && (x[22:0] == 0);
        yi = (y[30:23] == 255) && (y[22:0] == 0);
        xn = (x[30:23] == 255) && (x[22:0] != 0);
        yn = (y[30:23] == 255) && (y[22:0] != 0);
        if (xn || yn) return 32'h7FC00000;
        if ((xi && yi) || (xz && yz)) return 32'h7FC00000;
        if (xi || yz) return {s, 8'hFF, 23'd0};
        if (xz || yi) return {s, 8'h00, 23'd0};
        ex = int'(x[30:23]) - int'(y[30:23]) + 127;
        n  = longint'({1'b1, x[22:0]}) << 32;
        qq = n / longint'({1'b1, y[22:0]});
        rr = n % longint'({1'b1, y[22:0]});
        if (qq >= (64'd1 << 32)) sh = 9;
        else begin
            sh = 8;
            ex = ex - 1;
        end
        man  = qq >> sh;
        rest = qq & ((64'd1 << sh) - 1);
        half = 64'd1 << (sh - 1);
        up = (rest > half) || (rest == half && rr != 0) ||
             (rest == half && rr == 0 && man[0]);
        if (up) man = man + 1;
        if (man == (64'd1 << 24)) begin
            man = man >> 1;
            ex  = ex + 1;
        end
        if (ex >= 255) return {s, 8'hFF, 23'd0};
        if (ex <= 0) return {s, 8'h00, 23'd0};
        return {s, ex[7:0], man[22:0]};
    endfunction

    task automatic run_op(input logic [31:0] ta, input logic [31:0] tb,
                          input string tag);
        logic [31:0] ez;
        int          el;
        int          lat;
        ez = ref_div(ta, tb);
        el = is_special(ta, tb) ? 1 : 29;
        @(negedge clk);
        chk({tag, "_rdy"}, {31'd0, in_ready}, 32'd1);
        a = ta;
        b = tb;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        a = $urandom;
        b = $urandom;
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!out_valid && lat < 60);
        chk({tag, "_lat"}, lat, el);
        chk({tag, "_z"}, z, ez);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
    endtask

    function automatic logic [31:0] rand_fp();
        logic [7:0] ex;
        if ($urandom_range(0, 7) == 0) ex = 8'($urandom_range(0, 255));
        else ex = 8'($urandom_range(64, 190));
        return {1'($urandom_range(0, 1)), ex, 23'($urandom)};
    endfunction

    initial begin
        logic [31:0] held;
        int          seen;
        rst_n = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b0;
        a = '0;
        b = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_z", z, 32'd0);
        chk("rst_ov", {31'd0, out_valid}, 32'd0);
        chk("rst_ir", {31'd0, in_ready}, 32'd1);
        rst_n = 1'b1;

        run_op(32'h40C00000, 32'h40000000, "six_by_two");
        chk("six_by_two_const", z, 32'h40400000);
        run_op(32'h3F800000, 32'h40400000, "one_third");
        chk("one_third_const", z, 32'h3EAAAAAB);
        run_op(32'h3F800000, 32'h00000000, "one_by_zero");
        run_op(32'h00000000, 32'h00000000, "zero_by_zero");
        run_op(32'hBF800000, 32'h7F800000, "m1_by_inf");
        run_op(32'h7FC00001, 32'h3F800000, "nan_by_one");
        run_op(32'h7F800000, 32'h7F800000, "inf_by_inf");
        run_op(32'h7F7FFFFF, 32'h3E800000, "overflow");
        chk("overflow_const", z, 32'h7F800000);
        run_op(32'h00800000, 32'h40000000, "underflow");
        chk("underflow_const", z, 32'h00000000);

        // Back-pressure: result must be held while consumer stalls.
        @(negedge clk);
        a = 32'h40A00000;
        b = 32'h40800000;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        seen = 0;
        while (!out_valid && seen < 60) begin
            @(negedge clk);
            seen++;
        end
        held = ref_div(32'h40A00000, 32'h40800000);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            in_valid = 1'b1;
            a = $urandom;
            b = $urandom;
            @(posedge clk);
            #1;
            in_valid = 1'b0;
            chk("stall_z", z, held);
            chk("stall_ov", {31'd0, out_valid}, 32'd1);
            chk("stall_ir", {31'd0, in_ready}, 32'd0);
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        chk("stall_release", {31'd0, in_ready}, 32'd1);

        // Reset in the middle of the division loop.
        @(negedge clk);
        a = 32'h3F800000;
        b = 32'h40400000;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (12) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        chk("midrst_ir", {31'd0, in_ready}, 32'd1);
        chk("midrst_ov", {31'd0, out_valid}, 32'd0);
        chk("midrst_z", z, 32'd0);
        seen = 0;
        repeat (40) begin
            @(negedge clk);
            if (out_valid) seen++;
        end
        chk("midrst_no_out", seen, 0);
        run_op(32'h40C00000, 32'h40000000, "after_rst");

        for (int i = 0; i < 40; i++)
            run_op(rand_fp(), rand_fp(), $sformatf("rand%0d", i));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/fp32_div_seq.md
FP32_DIV_SEQ -- requirements
Module: fp32_div_seq

Interface
REQ-001 clk  input  1  single clock; all state changes on rising edge.
REQ-002 rst_n  input  1  synchronous, active-low reset, sampled on rising edge of clk.
REQ-003 in_valid  input  1  operand pair a/b valid.
REQ-004 in_ready  output  1  block idle, can accept operands.
REQ-005 a  input  32  IEEE-754 binary32 dividend.
REQ-006 b  input  32  IEEE-754 binary32 divisor.
REQ-007 out_valid  output  1  z holds a completed quotient.
REQ-008 out_ready  input  1  consumer accepts z.
REQ-009 z  output  32  binary32 quotient a/b.

Function
REQ-010 The block SHALL implement states IDLE, DIV, NORM, DONE; in_ready SHALL be 1 only in IDLE; out_valid SHALL be 1 only in DONE.
REQ-011 Transfer in SHALL occur on an edge with in_valid & in_ready; a and b SHALL be registered then and ignored afterwards.
REQ-012 Operand decode: exponent field 0 SHALL be treated as zero (denormals flushed); exponent 255 with mantissa 0 is infinity, with mantissa non-zero is NaN.
REQ-013 Special cases, in priority order, SHALL load z directly and go IDLE->DONE: any NaN -> 32'h7FC00000; inf/inf or 0/0 -> 32'h7FC00000; inf/x or x/0 -> {s,8'hFF,23'h0}; 0/x or x/inf -> {s,8'h00,23'h0}; s = a[31]^b[31].
REQ-014 Normal operands SHALL go IDLE->DIV; exponent held as 10-bit signed e = ea - eb + 127.
REQ-015 DIV SHALL run restoring division of {1,a[22:0]} by {1,b[22:0]}, one quotient bit per cycle, exactly 27 cycles, producing Q = floor(ma*2^26/mb) (27 bits) and remainder R; then NORM.
REQ-016 NORM: if Q[26]=1, mantissa = Q[26:3], guard = Q[2], sticky = Q[1]|Q[0]|(R!=0); else mantissa = Q[25:2], guard = Q[1], sticky = Q[0]|(R!=0), e = e-1.
REQ-017 Rounding SHALL be round-to-nearest-even: increment when guard & (sticky | mantissa[0]); carry out of bit 24 SHALL shift right by one and increment e.
REQ-018 After rounding, e >= 255 SHALL give {s,8'hFF,23'h0}; e <= 0 SHALL give {s,8'h00,23'h0} (no gradual underflow); otherwise {s,e[7:0],mantissa[22:0]}. NORM->DONE.
REQ-019 Latency: normal result SHALL be valid 29 edges after accept edge (27 DIV + 1 NORM + DONE entry); special result 1 edge after accept.
REQ-020 DONE SHALL hold z and out_valid stable until an edge with out_ready=1, then go IDLE; no new operand is accepted in the same edge (in_ready only in IDLE).
REQ-021 z SHALL change only on entry to DONE.

Reset
REQ-022 With rst_n=0 at an edge, state SHALL become IDLE, z = 32'h0, out_valid = 0, in_ready = 1 after that edge, from any state including mid-DIV; the in-flight operation SHALL be discarded with no output produced.
REQ-023 Iteration counter, Q, R and operand registers SHALL be cleared to 0 by reset.

Structure
REQ-024 Shared package fp32_pkg SHALL hold FP32_QNAN = 32'h7FC00000, FP32_BIAS = 127, FP32_EXP_MAX = 255, the state encoding, and DIV_ITERS = 27.
REQ-025 Rounding/packing (REQ-016..018) SHALL be one combinational sub-module fp32_rnd_pack (inputs sign, 10-bit e, 27-bit Q, sticky-remainder flag; output 32-bit word), reusable by the existing multiplier.
REQ-026 Divider datapath and FSM SHALL remain in fp32_div_seq; no multipliers inferred.

Verification
REQ-027 a=0x40C00000, b=0x40000000 -> z=0x40400000, out_valid 29 edges after accept.
REQ-028 a=0x3F800000, b=0x40400000 -> z=0x3EAAAAAB (round-up via sticky).
REQ-029 Specials: 1/0 -> 0x7F800000; 0/0 -> 0x7FC00000; -1/inf -> 0x80000000; NaN/1 -> 0x7FC00000; each valid 1 edge after accept.
REQ-030 a=0x7F7FFFFF, b=0x3E800000 -> z=0x7F800000 (overflow); a=0x00800000, b=0x40000000 -> z=0x00000000 (underflow flush).
REQ-031 out_ready held 0 for 10 cycles in DONE -> z, out_valid stable, in_ready=0; in_valid pulses ignored.
REQ-032 rst_n=0 at DIV iteration 12 -> IDLE next edge, out_valid never asserts; next operand pair then produces correct result.
